product_accumulator: RTL and testbench

- Downstream consumer of the 2-bit multiplier's 4-bit product (res).
- Sums a fixed number of products into one wider result, then presents it with a valid/ready handshake.
- Lets the multiplier stage feed a multiply-accumulate / dot-product path.
- Product input is registered on acceptance; no combinational path from prod to sum.

---
 rtl/product_accumulator_if.sv | 23 ++
 rtl/product_accumulator.sv | 140 ++++++++++++++
 tb/tb_product_accumulator.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Product input / result handshake bundle for product_accumulator.
// The block uses the slave view; the upstream/downstream driver uses master.
interface product_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             overflow;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, sum, overflow
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, sum, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT 4-bit products into an ACC_W-bit result and offers it on a valid/ready handshake.
// Optional macro PRODUCT_ACC_SATURATE_EN: clamp at 2^ACC_W-1 on carry instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    product_accumulator_if.slave bus
);
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);
`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
`endif

    state_t           state_r;
    state_t           state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W:0]   add_s;
    logic [7:0]       cnt_r;
    logic             ovf_acc_r;
    logic             ovf_nxt_s;
    logic             overflow_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             last_s;
    logic             take_s;

    assign accept_s = bus.in_valid && in_ready_s;
    assign last_s   = accept_s && (cnt_r == LAST_CNT);
    assign take_s   = out_valid_s && bus.out_ready;

    // Add one product with a spare carry bit; wrap or clamp on carry.
    always_comb begin
        add_s     = {1'b0, acc_r} + {{(ACC_W-3){1'b0}}, bus.prod};
        ovf_nxt_s = ovf_acc_r | add_s[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
        if (add_s[ACC_W]) begin
            acc_nxt_s = ACC_MAX;
        end else begin
            acc_nxt_s = add_s[ACC_W-1:0];
        end
`else
        acc_nxt_s = add_s[ACC_W-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; clear overrides both the last accept and the output handshake.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt_s = ST_ACCUM;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded straight from the state flop.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_ACCUM: in_ready_s  = 1'b1;
            ST_DONE:  out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Accumulator, product counter, sticky overflow and the held result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= 8'd0;
            ovf_acc_r  <= 1'b0;
            sum_r      <= {ACC_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (clear) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= 8'd0;
            ovf_acc_r  <= 1'b0;
            sum_r      <= {ACC_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (last_s) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= 8'd0;
            ovf_acc_r  <= 1'b0;
            sum_r      <= acc_nxt_s;
            overflow_r <= ovf_nxt_s;
        end else if (accept_s) begin
            acc_r      <= acc_nxt_s;
            cnt_r      <= cnt_r + 8'd1;
            ovf_acc_r  <= ovf_nxt_s;
        end else if (take_s) begin
            sum_r      <= {ACC_W{1'b0}};
            overflow_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.sum       = sum_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed and random checks of product_accumulator (default, ACC_W=5 and COUNT=1 instances).
module tb_product_accumulator;
    logic clk;
    logic rst;
    logic clear;
    int   total;
    int   bad;
    int   pa [200];
    int   pb [200];

    product_accumulator_if #(.ACC_W(8)) b8 ();
    product_accumulator_if #(.ACC_W(5)) b5 ();
    product_accumulator_if #(.ACC_W(8)) b1 ();

    product_accumulator #(.ACC_W(8), .COUNT(4)) dut  (.clk(clk), .rst(rst), .clear(clear), .bus(b8.slave));
    product_accumulator #(.ACC_W(5), .COUNT(4)) dut5 (.clk(clk), .rst(rst), .clear(clear), .bus(b5.slave));
    product_accumulator #(.ACC_W(8), .COUNT(1)) dut1 (.clk(clk), .rst(rst), .clear(clear), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed8(input logic [3:0] p);
        b8.in_valid = 1'b1;
        b8.prod     = p;
        tick();
        b8.in_valid = 1'b0;
    endtask

    task automatic feed5(input logic [3:0] p);
        b5.in_valid = 1'b1;
        b5.prod     = p;
        tick();
        b5.in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int results;
        int dut_hs;
        int cyc;
        int m_cnt;
        int m_acc;
        int m_sum;
        bit m_done;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear = 1'b0;
        b8.in_valid = 1'b0; b8.prod = 4'd0; b8.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.prod = 4'd0; b5.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.prod = 4'd0; b1.out_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            pa[i] = int'($urandom_range(0, 3));
            pb[i] = int'($urandom_range(0, 3));
        end

        // reset and idle
        #20 rst = 1'b1;
        repeat (5) tick();
        check_val("idle_in_ready", b8.in_ready, 1);
        check_val("idle_out_valid", b8.out_valid, 0);
        check_val("idle_sum", b8.sum, 0);
        check_val("idle_overflow", b8.overflow, 0);

        // basic sum 1+4+6+9
        b8.out_ready = 1'b1;
        feed8(4'd1);
        check_val("basic_no_early_valid", b8.out_valid, 0);
        feed8(4'd4);
        feed8(4'd6);
        feed8(4'd9);
        check_val("basic_out_valid", b8.out_valid, 1);
        check_val("basic_in_ready", b8.in_ready, 0);
        check_val("basic_sum", b8.sum, 20);
        check_val("basic_overflow", b8.overflow, 0);
        tick();
        check_val("basic_back_accum", b8.in_ready, 1);
        check_val("basic_valid_drop", b8.out_valid, 0);
        check_val("basic_sum_zero", b8.sum, 0);
        b8.out_ready = 1'b0;

        // gaps and backpressure: 2,0,3,1
        feed8(4'd2); tick();
        feed8(4'd0); tick(); tick();
        feed8(4'd3); tick();
        feed8(4'd1);
        b8.in_valid = 1'b1;
        b8.prod     = 4'd5;
        for (int i = 0; i < 3; i++) begin
            check_val("bp_out_valid", b8.out_valid, 1);
            check_val("bp_in_ready", b8.in_ready, 0);
            check_val("bp_sum", b8.sum, 6);
            tick();
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        check_val("bp_still_valid", b8.out_valid, 1);
        tick();
        check_val("bp_released", b8.out_valid, 0);
        b8.out_ready = 1'b0;

        // COUNT=1 instance: full-range product becomes the sum directly
        b1.in_valid = 1'b1;
        b1.prod     = 4'd15;
        tick();
        b1.in_valid = 1'b0;
        check_val("c1_out_valid", b1.out_valid, 1);
        check_val("c1_sum", b1.sum, 15);
        check_val("c1_in_ready", b1.in_ready, 0);
        b1.out_ready = 1'b1;
        tick();
        check_val("c1_released", b1.out_valid, 0);
        b1.out_ready = 1'b0;

        // overflow on ACC_W=5: 9*4 = 36
        feed5(4'd9); feed5(4'd9); feed5(4'd9);
        check_val("ovf_partial_valid", b5.out_valid, 0);
        feed5(4'd9);
        check_val("ovf_out_valid", b5.out_valid, 1);
        check_val("ovf_flag", b5.overflow, 1);
`ifdef PRODUCT_ACC_SATURATE_EN
        check_val("ovf_sum", b5.sum, 31);
`else
        check_val("ovf_sum", b5.sum, 4);
`endif
        b5.out_ready = 1'b1;
        tick();
        check_val("ovf_flag_cleared", b5.overflow, 0);
        check_val("ovf_released", b5.out_valid, 0);
        b5.out_ready = 1'b0;

        // clear drops the product presented with it
        feed8(4'd3); feed8(4'd3);
        clear       = 1'b1;
        b8.in_valid = 1'b1;
        b8.prod     = 4'd3;
        tick();
        clear       = 1'b0;
        b8.in_valid = 1'b0;
        check_val("clr_in_ready", b8.in_ready, 1);
        check_val("clr_out_valid", b8.out_valid, 0);
        feed8(4'd1); feed8(4'd1); feed8(4'd1); feed8(4'd1);
        check_val("clr_sum", b8.sum, 4);
        check_val("clr_valid", b8.out_valid, 1);
        // clear in DONE wins over the handshake and zeroes the result
        clear        = 1'b1;
        b8.out_ready = 1'b1;
        tick();
        clear        = 1'b0;
        b8.out_ready = 1'b0;
        check_val("clr_done_valid", b8.out_valid, 0);
        check_val("clr_done_sum", b8.sum, 0);

        // reset after two accepts loses the partial result
        feed8(4'd5); feed8(4'd5);
        rst = 1'b0;
        #2;
        check_val("rst_mid_valid", b8.out_valid, 0);
        check_val("rst_mid_sum", b8.sum, 0);
        #2 rst = 1'b1;
        feed8(4'd1); feed8(4'd1); feed8(4'd1); feed8(4'd1);
        check_val("rst_after_sum", b8.sum, 4);
        check_val("rst_after_valid", b8.out_valid, 1);
        // reset in DONE takes effect without a clock edge
        rst = 1'b0;
        #2;
        check_val("rst_done_valid", b8.out_valid, 0);
        check_val("rst_done_sum", b8.sum, 0);
        check_val("rst_done_overflow", b8.overflow, 0);
        #2 rst = 1'b1;
        tick();

        // random traffic against a cycle model
        idx     = 0;
        results = 0;
        dut_hs  = 0;
        cyc     = 0;
        m_cnt   = 0;
        m_acc   = 0;
        m_sum   = 0;
        m_done  = 1'b0;
        while ((idx < 200 || m_done) && cyc < 4000) begin
            check_val("rnd_in_ready", b8.in_ready, {31'd0, !m_done});
            check_val("rnd_out_valid", b8.out_valid, {31'd0, m_done});
            check_val("rnd_sum", b8.sum, m_done ? m_sum : 0);
            b8.in_valid  = (idx < 200) && ($urandom_range(0, 3) != 0);
            b8.prod      = (idx < 200) ? 4'(pa[idx] * pb[idx]) : 4'd0;
            b8.out_ready = ($urandom_range(0, 2) != 0);
            if (b8.out_valid && b8.out_ready) dut_hs++;
            if (m_done) begin
                if (b8.out_ready) begin
                    m_done = 1'b0;
                    results++;
                end
            end else if (b8.in_valid) begin
                m_acc += pa[idx] * pb[idx];
                idx++;
                m_cnt++;
                if (m_cnt == 4) begin
                    m_done = 1'b1;
                    m_sum  = m_acc;
                    m_acc  = 0;
                    m_cnt  = 0;
                end
            end
            tick();
            cyc++;
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b0;
        check_val("rnd_budget", {31'd0, cyc < 4000}, 1);
        check_val("rnd_results", results, 50);
        check_val("rnd_dut_handshakes", dut_hs, 50);
        check_val("rnd_final_idle", b8.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
